seven_seg_scanner: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes the 28-bit `displ` bus produced by `seven_seg_controller`, which carries four pre-encoded digit patterns, and lights one digit at a time through active-low anode enables. It freezes `displ` once per frame, so a register change in the middle of a frame cannot tear the display. It inserts blanking dead-time between digits to suppress ghosting.

---
 rtl/seven_seg_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner : 4-digit multiplexed 7-seg driver with frame snapshot and
//                     inter-digit blanking.                    Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_scanner #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [27:0] displ,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int                CNT_W       = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dig;
  logic [27:0]      r_snap;
  logic [0:0]       r_state;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_dig_nxt;
  logic [0:0]       w_state_nxt;
  logic             w_cnt_wrap;
  logic             w_frame_start;

  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_fd_nxt;

  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_fd;

  assign w_cnt_wrap    = (r_cnt == C_CNT_LAST);
  assign w_frame_start = en && (r_cnt == '0) && (r_dig == 2'd0);

  // Slot counter and digit index; disabling clears both so the scan restarts.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dig_nxt = r_dig;
    if (!en) begin
      w_cnt_nxt = '0;
      w_dig_nxt = 2'd0;
    end else if (w_cnt_wrap) begin
      w_cnt_nxt = '0;
      w_dig_nxt = r_dig + 2'd1;
    end else begin
      w_cnt_nxt = r_cnt + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= 28'h0;
    end else if (w_frame_start) begin
      r_snap <= displ;
    end
  end

  // r_state tracks the phase of the current r_cnt value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = (w_cnt_nxt < C_BLANK_END) ? S_BLANK : S_DRIVE;
  end

  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_fd_nxt  = 1'b0;
    if (en) begin
      w_fd_nxt = w_cnt_wrap && (r_dig == 2'd3);
      if (r_state == S_DRIVE) begin
        case (r_dig)
          2'd0: begin
            w_an_nxt  = 4'b1110;
            w_seg_nxt = r_snap[6:0];
          end
          2'd1: begin
            w_an_nxt  = 4'b1101;
            w_seg_nxt = r_snap[13:7];
          end
          2'd2: begin
            w_an_nxt  = 4'b1011;
            w_seg_nxt = r_snap[20:14];
          end
          default: begin
            w_an_nxt  = 4'b0111;
            w_seg_nxt = r_snap[27:21];
          end
        endcase
      end
    end
  end

  // Output registers; async reset blanks the display without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_fd  <= 1'b0;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_fd  <= w_fd_nxt;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_fd;

endmodule

`default_nettype wire
